// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/ack port between fetch (master) and memory (slave).
interface fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [31:0]       data;

    modport master (output req, addr, input ack, data);
    modport slave (input req, addr, output ack, data);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues imem fetches and hands instructions to decode,
// with redirects, decode stalls, halt and fetch-timeout faults.
module fetch_sequencer #(
    parameter int                ADDR_W       = 64,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [7:0]        MAX_WAIT     = 8'd15
) (
    input  logic               clock,
    input  logic               reset,
    fetch_sequencer_if.master  imem,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               fault
);
    // One-hot so every status output is a direct flop bit
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        REQ    = 5'b00010,
        VALID  = 5'b00100,
        HALTED = 5'b01000,
        FAULT  = 5'b10000
    } state_t;

    state_t            state, state_nx;
    logic [7:0]        wait_cnt;
    logic              redir_pend, halt_pend;
    logic [ADDR_W-1:0] redir_tgt, redir_addr;
    logic              halt_now, redir_now, misaligned, timeout;

    assign halt_now   = halt | halt_pend;
    assign redir_now  = branch_taken | redir_pend;
    // A same-cycle branch overrides any redirect latched earlier in the fetch
    assign redir_addr = branch_taken ? branch_target : redir_tgt;
    assign misaligned = redir_addr[1:0] != 2'b00;
    assign timeout    = !imem.ack && wait_cnt == MAX_WAIT - 8'd1;

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = halt_now ? HALTED : REQ;
            REQ:     state_nx = imem.ack ? (!redir_now ? VALID : misaligned ? FAULT : REQ)
                                         : (timeout ? FAULT : REQ);
            VALID:   state_nx = branch_taken ? (misaligned ? FAULT : halt_now ? HALTED : REQ)
                                             : (stall ? VALID : halt_now ? HALTED : REQ);
            default: state_nx = state;
        endcase
    end

    always_comb begin
        imem.req    = state == REQ;
        instr_valid = state == VALID;
        fault       = state == FAULT;
    end

    assign imem.addr = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_VECTOR;
            instr      <= '0;
            instr_pc   <= '0;
            wait_cnt   <= '0;
            redir_pend <= 1'b0;
            redir_tgt  <= '0;
            halt_pend  <= 1'b0;
        end else begin
            if (halt)
                halt_pend <= 1'b1;
            case (state)
                REQ: begin
                    if (imem.ack) begin
                        wait_cnt   <= '0;
                        redir_pend <= 1'b0;
                        if (redir_now) begin
                            pc <= redir_addr;
                        end else begin
                            instr    <= imem.data;
                            instr_pc <= pc;
                            pc       <= pc + ADDR_W'(4);
                        end
                    end else begin
                        if (!timeout)
                            wait_cnt <= wait_cnt + 8'd1;
                        if (branch_taken) begin
                            redir_pend <= 1'b1;
                            redir_tgt  <= branch_target;
                        end
                    end
                end
                VALID: if (branch_taken) pc <= branch_target;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenario tasks plus a randomized run checked against a
// transaction-level model of the fetch stream.
module tb_fetch_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        halt = 1'b0;
    logic [63:0] branch_target = '0;
    logic [63:0] pc, instr_pc;
    logic        instr_valid, fault;
    logic [31:0] instr;
    int          tests = 0;
    int          fails = 0;

    fetch_sequencer_if #(.ADDR_W(64)) mem ();

    fetch_sequencer dut (
        .clock(clock), .reset(reset), .imem(mem), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
        .pc(pc), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .fault(fault)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [63:0] a);
        return 32'h8B000000 + a[33:2];
    endfunction

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        halt = 1'b0;
        mem.ack = 1'b0;
        mem.data = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic run_seq(input int n);
        repeat (n) begin
            mem.ack = mem.req;
            mem.data = word(mem.addr);
            tick;
        end
        mem.ack = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; mem.ack = 1'b1; mem.data = 32'hFFFFFFFF;
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h123; halt = 1'b1;
        tick;
        tick;
        tests++;
        if ({mem.req, instr_valid, fault} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got %b want 000", {mem.req, instr_valid, fault});
        end
        tests++;
        if (pc !== 64'h0) begin fails++; $display("FAIL reset_pc got %h want 0", pc); end
        tests++;
        if (instr !== 32'h0 || instr_pc !== 64'h0) begin
            fails++; $display("FAIL reset_instr got %h/%h want 0/0", instr, instr_pc);
        end
        stall = 1'b0; branch_taken = 1'b0; halt = 1'b0; mem.ack = 1'b0; reset = 1'b0;
        tick;
        tests++;
        if (mem.req !== 1'b1 || mem.addr !== 64'h0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=0", mem.req, mem.addr);
        end
    endtask

    task automatic test_sequential;
        logic ev;
        logic [63:0] ea;
        do_reset;
        for (int c = 1; c <= 8; c++) begin
            mem.ack = mem.req;
            mem.data = word(mem.addr);
            tick;
            ev = (c % 2) == 0;
            ea = 64'(4 * (c / 2 - 1));
            tests++;
            if (instr_valid !== ev || mem.req !== !ev) begin
                fails++; $display("FAIL seq_cycle%0d got valid=%b req=%b want valid=%b", c, instr_valid, mem.req, ev);
            end else if (ev && (instr_pc !== ea || instr !== word(ea))) begin
                fails++; $display("FAIL seq_item%0d got %h@%h want %h@%h", c, instr, instr_pc, word(ea), ea);
            end
        end
        mem.ack = 1'b0;
    endtask

    task automatic test_ack_delay;
        do_reset;
        run_seq(8);
        for (int k = 0; k < 4; k++) begin
            tick;
            tests++;
            if (mem.req !== 1'b1 || mem.addr !== 64'h10) begin
                fails++; $display("FAIL delay_hold%0d got req=%b addr=%h want 1/10", k, mem.req, mem.addr);
            end
        end
        mem.ack = 1'b1; mem.data = 32'hA5A50010;
        tick;
        mem.ack = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || instr !== 32'hA5A50010 || instr_pc !== 64'h10 || pc !== 64'h14) begin
            fails++; $display("FAIL delay_deliver got v=%b %h@%h pc=%h want 1 a5a50010@10 pc=14", instr_valid, instr, instr_pc, pc);
        end
    endtask

    task automatic test_redirect;
        do_reset;
        run_seq(4);
        tick;
        branch_taken = 1'b1; branch_target = 64'h200;
        tick;
        branch_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (mem.req !== 1'b1 || mem.addr !== 64'h8 || instr_valid !== 1'b0) begin
                fails++; $display("FAIL redir_hold%0d got req=%b addr=%h want 1/8", k, mem.req, mem.addr);
            end
            if (k == 0) tick;
        end
        mem.ack = 1'b1; mem.data = 32'hDEADBEEF;
        tick;
        tests++;
        if (instr_valid !== 1'b0 || mem.req !== 1'b1 || mem.addr !== 64'h200) begin
            fails++; $display("FAIL redir_drop got v=%b req=%b addr=%h want 0/1/200", instr_valid, mem.req, mem.addr);
        end
        mem.data = word(64'h200);
        tick;
        mem.ack = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h200 || instr !== word(64'h200)) begin
            fails++; $display("FAIL redir_fetch got v=%b %h@%h want 1 %h@200", instr_valid, instr, instr_pc, word(64'h200));
        end
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h300;
        tick;
        stall = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || mem.req !== 1'b1 || mem.addr !== 64'h300) begin
            fails++; $display("FAIL redir_over_stall got v=%b req=%b addr=%h want 0/1/300", instr_valid, mem.req, mem.addr);
        end
        branch_target = 64'h400; mem.ack = 1'b1; mem.data = 32'h00000BAD;
        tick;
        branch_taken = 1'b0; mem.ack = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || mem.req !== 1'b1 || mem.addr !== 64'h400) begin
            fails++; $display("FAIL redir_with_ack got v=%b req=%b addr=%h want 0/1/400", instr_valid, mem.req, mem.addr);
        end
    endtask

    task automatic test_stall;
        do_reset;
        run_seq(2);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            tests++;
            if (instr_valid !== 1'b1 || mem.req !== 1'b0 || instr_pc !== 64'h0 || instr !== word(64'h0)) begin
                fails++; $display("FAIL stall_hold%0d got v=%b req=%b %h@%h want 1/0 %h@0", k, instr_valid, mem.req, instr, instr_pc, word(64'h0));
            end
        end
        stall = 1'b0;
        tick;
        tests++;
        if (mem.req !== 1'b1 || mem.addr !== 64'h4 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL stall_release got req=%b addr=%h want 1/4", mem.req, mem.addr);
        end
    endtask

    task automatic test_timeout;
        int n;
        do_reset;
        n = 0;
        for (int k = 0; k < 40 && !fault; k++) begin
            tick;
            if (mem.req === 1'b1) n++;
        end
        tests++;
        if (n != 15 || fault !== 1'b1 || mem.req !== 1'b0 || pc !== 64'h0) begin
            fails++; $display("FAIL timeout got req_cycles=%0d fault=%b req=%b pc=%h want 15/1/0/0", n, fault, mem.req, pc);
        end
        mem.ack = 1'b1; branch_taken = 1'b1; branch_target = 64'h40;
        tick;
        tick;
        mem.ack = 1'b0; branch_taken = 1'b0;
        tests++;
        if (fault !== 1'b1 || mem.req !== 1'b0 || pc !== 64'h0) begin
            fails++; $display("FAIL fault_sticky got fault=%b req=%b pc=%h want 1/0/0", fault, mem.req, pc);
        end
        do_reset;
        tests++;
        if (fault !== 1'b0) begin fails++; $display("FAIL fault_clear got %b want 0", fault); end
    endtask

    task automatic test_misaligned;
        do_reset;
        run_seq(2);
        branch_taken = 1'b1; branch_target = 64'h202;
        tick;
        branch_taken = 1'b0;
        tests++;
        if (fault !== 1'b1 || instr_valid !== 1'b0 || mem.req !== 1'b0 || pc !== 64'h202) begin
            fails++; $display("FAIL misalign_valid got fault=%b v=%b pc=%h want 1/0/202", fault, instr_valid, pc);
        end
        do_reset;
        run_seq(1);
        branch_taken = 1'b1; branch_target = 64'h202;
        tick;
        branch_taken = 1'b0;
        tests++;
        if (fault !== 1'b0 || mem.req !== 1'b1 || mem.addr !== 64'h0) begin
            fails++; $display("FAIL misalign_req_wait got fault=%b req=%b addr=%h want 0/1/0", fault, mem.req, mem.addr);
        end
        mem.ack = 1'b1; mem.data = word(64'h0);
        tick;
        mem.ack = 1'b0;
        tests++;
        if (fault !== 1'b1 || instr_valid !== 1'b0 || pc !== 64'h202) begin
            fails++; $display("FAIL misalign_req got fault=%b v=%b pc=%h want 1/0/202", fault, instr_valid, pc);
        end
    endtask

    task automatic test_halt;
        do_reset;
        run_seq(16);
        tick;
        tests++;
        if (mem.req !== 1'b1 || mem.addr !== 64'h20) begin
            fails++; $display("FAIL halt_setup got req=%b addr=%h want 1/20", mem.req, mem.addr);
        end
        halt = 1'b1;
        tick;
        halt = 1'b0; mem.ack = 1'b1; mem.data = word(64'h20);
        tick;
        mem.ack = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'h20 || instr !== word(64'h20)) begin
            fails++; $display("FAIL halt_inflight got v=%b %h@%h want 1 %h@20", instr_valid, instr, instr_pc, word(64'h20));
        end
        tick;
        tests++;
        if (mem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== 64'h24) begin
            fails++; $display("FAIL halt_enter got req=%b v=%b pc=%h want 0/0/24", mem.req, instr_valid, pc);
        end
        branch_taken = 1'b1; branch_target = 64'h100; mem.ack = 1'b1;
        tick;
        tick;
        branch_taken = 1'b0; mem.ack = 1'b0;
        tests++;
        if (mem.req !== 1'b0 || instr_valid !== 1'b0 || fault !== 1'b0 || pc !== 64'h24) begin
            fails++; $display("FAIL halt_frozen got req=%b v=%b fault=%b pc=%h want 0/0/0/24", mem.req, instr_valid, fault, pc);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        run_seq(2);
        branch_taken = 1'b1; branch_target = 64'hFFFFFFFFFFFFFFFC;
        tick;
        branch_taken = 1'b0;
        tests++;
        if (mem.req !== 1'b1 || mem.addr !== 64'hFFFFFFFFFFFFFFFC) begin
            fails++; $display("FAIL wrap_req got req=%b addr=%h want 1/fffffffffffffffc", mem.req, mem.addr);
        end
        mem.ack = 1'b1; mem.data = 32'h13579BDF;
        tick;
        mem.ack = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 64'hFFFFFFFFFFFFFFFC || instr !== 32'h13579BDF || pc !== 64'h0) begin
            fails++; $display("FAIL wrap_pc got v=%b %h@%h pc=%h want 1 13579bdf@fffffffffffffffc pc=0", instr_valid, instr, instr_pc, pc);
        end
    endtask

    // Model tracks the instruction stream only: next fetch address, any redirect
    // requested during the current fetch, and the item currently offered to decode.
    task automatic test_random;
        logic [63:0] exp_fetch, redir_tgt, item_pc, tgt;
        logic [31:0] item_data, d;
        logic        have_item, redir, br, ack, st;
        int          waits;
        do_reset;
        tick;
        exp_fetch = '0; redir_tgt = '0; item_pc = '0; item_data = '0;
        have_item = 1'b0; redir = 1'b0; waits = 0;
        for (int i = 0; i < 600; i++) begin
            tests++;
            if (instr_valid !== have_item || mem.req !== !have_item || fault !== 1'b0) begin
                fails++; $display("FAIL rnd_state@%0d got v=%b req=%b fault=%b want v=%b", i, instr_valid, mem.req, fault, have_item);
            end else if (have_item && (instr_pc !== item_pc || instr !== item_data)) begin
                fails++; $display("FAIL rnd_item@%0d got %h@%h want %h@%h", i, instr, instr_pc, item_data, item_pc);
            end else if (!have_item && mem.addr !== exp_fetch) begin
                fails++; $display("FAIL rnd_addr@%0d got %h want %h", i, mem.addr, exp_fetch);
            end
            st = $urandom_range(0, 2) == 0;
            br = $urandom_range(0, 7) == 0;
            tgt = 64'($urandom_range(0, 1023)) << 2;
            ack = !have_item && (waits >= 10 || $urandom_range(0, 2) != 0);
            d = $urandom;
            stall = st; branch_taken = br; branch_target = tgt; mem.ack = ack; mem.data = d;
            if (!have_item) begin
                if (ack) begin
                    waits = 0;
                    if (br || redir) begin
                        exp_fetch = br ? tgt : redir_tgt;
                        redir = 1'b0;
                    end else begin
                        item_pc = exp_fetch;
                        item_data = d;
                        have_item = 1'b1;
                        exp_fetch = exp_fetch + 64'd4;
                    end
                end else begin
                    waits++;
                    if (br) begin
                        redir = 1'b1;
                        redir_tgt = tgt;
                    end
                end
            end else if (br) begin
                exp_fetch = tgt;
                have_item = 1'b0;
            end else if (!st) begin
                have_item = 1'b0;
            end
            tick;
        end
        stall = 1'b0; branch_taken = 1'b0; mem.ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        mem.ack = 1'b0;
        mem.data = '0;
        @(negedge clock);
        test_reset;
        test_sequential;
        test_ack_delay;
        test_redirect;
        test_stall;
        test_timeout;
        test_misaligned;
        test_halt;
        test_wrap;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch controller that owns and sequences the 64-bit program counter for the single-issue core. It issues instruction-memory requests with a req/ack handshake, delivers each fetched instruction with its PC to decode, and applies branch redirects, decode stalls, halt and fetch-timeout faults. It sits between the instruction memory port and the decode stage.

Parameters:
ADDR_W, 64, PC and address width
RESET_VECTOR, 64'h0, PC value loaded on reset
MAX_WAIT, 15, REQ cycles without ack before FAULT (width 8 bits, 1..255)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  fetch address, equals pc, stable while imem_req=1
imem_ack  in  1  memory completes fetch this cycle
imem_data  in  32  instruction word, valid when imem_ack=1
stall  in  1  decode cannot accept instr this cycle
branch_taken  in  1  redirect request, one-cycle pulse
branch_target  in  ADDR_W  redirect address, valid with branch_taken
halt  in  1  stop fetching at next instruction boundary
pc  out  ADDR_W  address of the next fetch
instr_valid  out  1  instr/instr_pc valid for decode
instr  out  32  fetched instruction
instr_pc  out  ADDR_W  address of instr
fault  out  1  sticky fault flag

Behaviour:
- Reset (reset, clock as decided: synchronous, active-high, rising edge of clock): pc=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fault=0, wait counter=0, pending flags clear, state IDLE. Reset overrides every other input, including mid-request; an outstanding ack after reset is ignored.
- States: IDLE, REQ, VALID, HALTED, FAULT. All outputs registered.
- IDLE: next edge -> REQ, unless halt=1 -> HALTED. imem_req rises the first cycle after reset deasserts.
- REQ: imem_req=1, imem_addr=pc. Wait counter increments each cycle with imem_ack=0. When it reaches MAX_WAIT with no ack -> FAULT.
- REQ with imem_ack=1 and no redirect pending: instr<=imem_data, instr_pc<=pc, pc<=pc+4 (modulo 2^ADDR_W, wraps to 0), -> VALID. Zero-wait ack gives instr_valid one cycle after imem_req rises.
- branch_taken during REQ without ack: request is not aborted. Latch target as a pending redirect; a later branch_taken before ack overwrites it. On ack: drop the data, pc<=pending target, clear pending, re-enter REQ (imem_req deasserts for 0 cycles, address changes on the same edge).
- branch_taken in the same cycle as ack: same as pending redirect. Data dropped, pc<=branch_target, stay REQ.
- VALID: instr_valid=1, imem_req=0. Both stall=0 and branch_taken=0: instruction consumed, -> REQ (or HALTED if halt is pending). stall=1: hold instr, instr_pc and instr_valid unchanged. branch_taken: has priority over stall. instr_valid drops next cycle, pc<=branch_target, -> REQ.
- Throughput: one instruction per 2 cycles with zero-wait memory.
- halt: halt=1 latches halt-pending in any state. Takes effect only at a boundary with no request outstanding (IDLE, or VALID when consumed/redirected). An in-flight fetch completes and is delivered first. HALTED: imem_req=0, instr_valid=0, pc frozen. Exit only by reset.
- Misaligned redirect: branch_target[1:0]!=0 -> FAULT on the next edge. In REQ the fault waits for ack first.
- FAULT: fault=1, imem_req=0, instr_valid=0, pc holds the offending address (timeout address or misaligned target). Sticky until reset.
- Inputs in HALTED/FAULT are ignored.

Test Plan:
- Reset then ack every REQ cycle with data 0x8B000000+n: instr_pc sequence 0,4,8,12, instr_valid every other cycle, first instr_valid 2 cycles after reset falls.
- Ack delayed 3 cycles at pc=0x10: imem_req high and imem_addr=0x10 stable for 4 cycles. instr=data, pc=0x14 after.
- branch_taken target 0x200 two cycles before ack of pc=0x8: ack data dropped (instr_valid stays 0). Next imem_addr=0x200. Also branch+stall in VALID: redirect wins.
- stall held 5 cycles in VALID: instr, instr_pc stable, imem_req=0 throughout. Release: REQ at next pc.
- No ack for MAX_WAIT=15 cycles: fault=1 at cycle 15, imem_req=0, pc=faulting address. Also target 0x202 -> fault. Reset clears fault.
- halt pulsed during REQ at pc=0x20: instr at 0x20 delivered, then HALTED with imem_req=0. pc=0xFFFFFFFFFFFFFFFC fetch wraps pc to 0.
